// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg -- shared constants for the MUL AB / DIV AB sequencer.
//   SFR_ACC / SFR_B       : SFR byte addresses of the ACC and B registers
//   MULDIV_OP_MUL / _DIV  : encodings of the op input
//   PART_W                : width of the shared partial-result register
//   state_t               : sequencer states
package muldiv_ctrl_pkg;

    localparam logic [7:0] SFR_ACC = 8'hE0;
    localparam logic [7:0] SFR_B   = 8'hF0;

    localparam logic MULDIV_OP_MUL = 1'b0;
    localparam logic MULDIV_OP_DIV = 1'b1;

    // {9-bit high half, 8-bit low half}: product/multiplier for MUL,
    // partial remainder/quotient for DIV.
    localparam int PART_W = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WR_A,
        S_WR_B,
        S_DONE
    } state_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if -- SFR write port shared between the core and the sequencer.
//   sfr_req  : write request, held until acknowledged
//   sfr_ack  : port granted; the write happens in a cycle with req & ack
//   sfr_addr : SFR byte address
//   sfr_data : write data
// master = requester (muldiv_ctrl), slave = SFR port arbiter.
interface muldiv_ctrl_if;
    logic       sfr_req;
    logic       sfr_ack;
    logic [7:0] sfr_addr;
    logic [7:0] sfr_data;

    modport master (output sfr_req, output sfr_addr, output sfr_data, input sfr_ack);
    modport slave  (input sfr_req, input sfr_addr, input sfr_data, output sfr_ack);
endinterface

// File: rtl/muldiv_ctrl_iter.sv
// muldiv_iter -- one combinational iteration of shift-add multiply or
// restoring divide on the shared 17-bit partial register.
//   op       : MULDIV_OP_MUL or MULDIV_OP_DIV
//   part     : current partial result
//   opnd     : multiplicand (MUL) or divisor (DIV)
//   part_nxt : partial result after this iteration
// The divide step is only built when MULDIV_DIV_EN is defined.
module muldiv_iter
    import muldiv_ctrl_pkg::*;
(
    input  logic              op,
    input  logic [PART_W-1:0] part,
    input  logic [7:0]        opnd,
    output logic [PART_W-1:0] part_nxt
);

    logic [8:0] sum;
    logic [PART_W-1:0] mul_nxt;

    // MUL: high half accumulates the multiplicand when the multiplier LSB
    // (part[0]) is set, then the whole register shifts right one place.
    // After 8 steps part[15:0] holds the product.
    always_comb begin
        sum     = part[16:8] + {1'b0, opnd & {8{part[0]}}};
        mul_nxt = {1'b0, sum, part[7:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [8:0] shl;
    logic [8:0] diff;
    logic       fits;
    logic [PART_W-1:0] div_nxt;

    // DIV: remainder shifts in the next dividend bit from the top of the
    // low half; quotient bits shift in at the bottom. The remainder stays
    // below the divisor, so R<<1 always fits in 9 bits.
    always_comb begin
        shl     = {part[15:8], part[7]};
        diff    = shl - {1'b0, opnd};
        fits    = (shl >= {1'b0, opnd});
        div_nxt = {(fits ? diff : shl), part[6:0], fits};
    end

    assign part_nxt = (op == MULDIV_OP_DIV) ? div_nxt : mul_nxt;
`else
    logic unused_op;
    assign unused_op = op;
    assign part_nxt  = mul_nxt;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- multi-cycle sequencer for 8051 MUL AB / DIV AB.
//   clock, reset : clock, asynchronous active-high reset
//   start, op    : one-cycle request (sampled in IDLE), 0 = MUL, 1 = DIV
//   a_in, b_in   : ACC and B operands
//   busy, done   : busy outside IDLE, one-cycle completion pulse
//   ov, cy       : PSW flags, held until the next accepted start
//   sfr          : SFR write port (master side); A is written, then B
// Build option: MULDIV_DIV_EN compiles in the divider. Without it every
// DIV request completes like a divide by zero (ov = 1, no writes).
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          op,
    input  logic [7:0]    a_in,
    input  logic [7:0]    b_in,
    output logic          busy,
    output logic          done,
    output logic          ov,
    output logic          cy,
    muldiv_ctrl_if.master sfr
);

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [7:0]        opnd_q, opnd_d;
    logic [PART_W-1:0] part_q, part_d;
    logic [PART_W-1:0] part_nxt;
    logic [2:0]        cnt_q, cnt_d;
    logic              ov_q, ov_d;
    logic              cy_q, cy_d;
    logic              req_q, req_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              div_reject;

`ifdef MULDIV_DIV_EN
    assign div_reject = (op == MULDIV_OP_DIV) && (b_in == 8'h00);
`else
    assign div_reject = (op == MULDIV_OP_DIV);
`endif

    muldiv_iter u_iter (
        .op       (op_q),
        .part     (part_q),
        .opnd     (opnd_q),
        .part_nxt (part_nxt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= MULDIV_OP_MUL;
            opnd_q  <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            cy_q    <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            cy_q    <= cy_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        cy_d    = cy_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    ov_d  = 1'b0;
                    cy_d  = 1'b0;
                    // Low half seeds with the operand consumed bit by bit.
                    if (op == MULDIV_OP_DIV) begin
                        part_d = {{(PART_W-8){1'b0}}, a_in};
                        opnd_d = b_in;
                    end else begin
                        part_d = {{(PART_W-8){1'b0}}, b_in};
                        opnd_d = a_in;
                    end
                    if (div_reject) begin
                        ov_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                part_d = part_nxt;
                cnt_d  = cnt_q + 3'd1;
                // Last step: load the A write directly from the final
                // iteration so req is registered high in the first WR_A cycle.
                if (cnt_q == 3'd7) begin
                    state_d = S_WR_A;
                    req_d   = 1'b1;
                    addr_d  = SFR_ACC;
                    data_d  = part_nxt[7:0];
                    ov_d    = (op_q == MULDIV_OP_MUL) && (part_nxt[15:8] != 8'h00);
                end
            end
            S_WR_A: begin
                if (sfr.sfr_ack) begin
                    state_d = S_WR_B;
                    addr_d  = SFR_B;
                    data_d  = part_q[15:8];
                end
            end
            S_WR_B: begin
                if (sfr.sfr_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign ov           = ov_q;
    assign cy           = cy_q;
    assign sfr.sfr_req  = req_q;
    assign sfr.sfr_addr = addr_q;
    assign sfr.sfr_data = data_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl -- self-checking bench for muldiv_ctrl. Expected results
// come from integer arithmetic on the operands; cycle numbers count clock
// edges after the edge that samples start.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       op    = 1'b0;
    logic [7:0] a_in  = 8'h00;
    logic [7:0] b_in  = 8'h00;
    logic       busy, done, ov, cy;

    muldiv_ctrl_if sfr ();

    muldiv_ctrl dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .ov    (ov),
        .cy    (cy),
        .sfr   (sfr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural result of MUL AB / DIV AB.
    function automatic void model(input logic o, input logic [7:0] a, input logic [7:0] b,
                                  output int nw, output logic [7:0] ea, output logic [7:0] eb,
                                  output logic eov);
        int  p;
        bit  div_ok;
`ifdef MULDIV_DIV_EN
        div_ok = (b != 8'h00);
`else
        div_ok = 1'b0;
`endif
        if (o == 1'b0) begin
            p   = int'(a) * int'(b);
            ea  = 8'(p);
            eb  = 8'(p >> 8);
            eov = (eb != 8'h00);
            nw  = 2;
        end else if (div_ok) begin
            ea  = 8'(int'(a) / int'(b));
            eb  = 8'(int'(a) % int'(b));
            eov = 1'b0;
            nw  = 2;
        end else begin
            ea  = 8'h00;
            eb  = 8'h00;
            eov = 1'b1;
            nw  = 0;
        end
    endfunction

    // Issue one operation and watch it to completion. The first 'stalls'
    // request cycles see ack low; start is re-pulsed with junk operands in
    // cycles inj1/inj2 (0 = never).
    task automatic run_op(input string name, input logic o, input logic [7:0] a, input logic [7:0] b,
                          input int stalls, input int inj1, input int inj2, input bit check_idle);
        int         nw;
        logic [7:0] ea, eb;
        logic       eov;
        int         exp_done, got_w, done_c, busy_err, hold_err, stall_left;
        logic [7:0] wa[2];
        logic [7:0] wd[2];
        int         wc[2];
        logic [7:0] xa, xd;
        model(o, a, b, nw, ea, eb, eov);
        exp_done = (nw == 0) ? 1 : 11 + stalls;
        got_w = 0; done_c = 0; busy_err = 0; hold_err = 0; stall_left = stalls;
        wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0; wc[0] = 0; wc[1] = 0;
        @(negedge clock);
        op = o; a_in = a; b_in = b; start = 1'b1; sfr.sfr_ack = 1'b1;
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            @(negedge clock);
            start = (c == inj1) || (c == inj2);
            op    = 1'($urandom);
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            if (busy !== 1'b1) busy_err++;
            if (sfr.sfr_req === 1'b1) begin
                xa = (got_w == 0) ? SFR_ACC : SFR_B;
                xd = (got_w == 0) ? ea : eb;
                if (got_w >= 2 || sfr.sfr_addr !== xa || sfr.sfr_data !== xd) hold_err++;
                if (stall_left > 0) begin
                    sfr.sfr_ack = 1'b0;
                    stall_left--;
                end else begin
                    sfr.sfr_ack = 1'b1;
                end
                if (sfr.sfr_ack) begin
                    if (got_w < 2) begin
                        wa[got_w] = sfr.sfr_addr;
                        wd[got_w] = sfr.sfr_data;
                        wc[got_w] = c;
                    end
                    got_w++;
                end
            end else begin
                sfr.sfr_ack = 1'b1;
            end
            if (done === 1'b1) done_c = c;
        end

        n_checks++;
        if (done_c !== exp_done) $display("FAIL %s done_cycle: got %0d expected %0d (0 = timeout)", name, done_c, exp_done);
        else n_pass++;
        n_checks++;
        if (got_w !== nw) $display("FAIL %s write_count: got %0d expected %0d", name, got_w, nw);
        else n_pass++;
        if (nw == 2) begin
            n_checks++;
            if (wa[0] !== SFR_ACC || wd[0] !== ea || wc[0] !== 9 + stalls)
                $display("FAIL %s write_a: got %h/%h@%0d expected %h/%h@%0d", name, wa[0], wd[0], wc[0], SFR_ACC, ea, 9 + stalls);
            else n_pass++;
            n_checks++;
            if (wa[1] !== SFR_B || wd[1] !== eb || wc[1] !== 10 + stalls)
                $display("FAIL %s write_b: got %h/%h@%0d expected %h/%h@%0d", name, wa[1], wd[1], wc[1], SFR_B, eb, 10 + stalls);
            else n_pass++;
        end
        n_checks++;
        if (ov !== eov || cy !== 1'b0) $display("FAIL %s flags: got ov=%b cy=%b expected ov=%b cy=0", name, ov, cy, eov);
        else n_pass++;
        n_checks++;
        if (busy_err != 0 || hold_err != 0) $display("FAIL %s busy/hold: got %0d/%0d bad cycles expected 0/0", name, busy_err, hold_err);
        else n_pass++;
        if (check_idle) begin
            @(negedge clock);
            start = 1'b0;
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || sfr.sfr_req !== 1'b0 || ov !== eov)
                $display("FAIL %s after_done: got busy=%b done=%b req=%b ov=%b expected 0/0/0/%b", name, busy, done, sfr.sfr_req, ov, eov);
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        sfr.sfr_ack = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({busy, done, ov, cy, sfr.sfr_req, sfr.sfr_addr, sfr.sfr_data} !== 21'd0)
            $display("FAIL reset_values: got %b%b%b%b%b %h %h expected all zero", busy, done, ov, cy, sfr.sfr_req, sfr.sfr_addr, sfr.sfr_data);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_mul;       run_op("mul_50_a0",   1'b0, 8'h50, 8'hA0, 0, 0, 0, 1'b1); endtask
    task automatic test_div;       run_op("div_fb_12",   1'b1, 8'hFB, 8'h12, 0, 0, 0, 1'b1); endtask
    task automatic test_div_zero;  run_op("div_by_zero", 1'b1, 8'h42, 8'h00, 0, 0, 0, 1'b1); endtask
    task automatic test_stall;     run_op("mul_stall",   1'b0, 8'h0F, 8'h11, 3, 0, 0, 1'b1); endtask

    task automatic test_back_to_back;
        run_op("ignored_start", 1'b0, 8'($urandom), 8'($urandom), 0, 4, 11, 1'b0);
        run_op("accept_c12", 1'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 0, 0, 0, 1'b1);
    endtask

    task automatic test_reset_abort;
        int bad;
        bad = 0;
        @(negedge clock);
        op = 1'b0; a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, ov, cy, sfr.sfr_req, sfr.sfr_addr, sfr.sfr_data} !== 21'd0)
            $display("FAIL abort_values: got %b%b%b%b%b %h %h expected all zero", busy, done, ov, cy, sfr.sfr_req, sfr.sfr_addr, sfr.sfr_data);
        else n_pass++;
        repeat (3) begin
            @(negedge clock);
            if (busy !== 1'b0 || done !== 1'b0 || sfr.sfr_req !== 1'b0) bad++;
        end
        reset = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (busy !== 1'b0 || done !== 1'b0 || sfr.sfr_req !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
        else n_pass++;
        run_op("after_reset", 1'b0, 8'($urandom), 8'($urandom), 1, 0, 0, 1'b1);
    endtask

    task automatic test_random;
        logic [7:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            run_op($sformatf("rand%0d", i), 1'($urandom), a, b, $urandom_range(0, 3), 0, 0, 1'b1);
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_div_zero;
        test_stall;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
